// File: rtl/hft_ts_pkg.sv
// purpose: shared defaults and helpers for the rx-to-tx latency tagging block
// latency: n/a (types, constants and a constant function only)
// backpressure: n/a
package hft_ts_pkg;

   localparam int unsigned CNT_W_DEF   = 32;
   localparam int unsigned DEPTH_DEF   = 8;
   localparam int unsigned TIMEOUT_DEF = 0;

   // Occupancy needs one bit more than the address so that DEPTH itself fits.
   function automatic int unsigned occ_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/ts_tag_fifo.sv
// purpose: in-order store of rx timestamps (tags) awaiting their tx response
// latency: head is combinational from the array; a push is visible at the head next cycle
// backpressure: none upstream; a push while full is ignored unless a pop frees the slot that cycle
module ts_tag_fifo
   import hft_ts_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF,
   parameter int unsigned DEPTH = DEPTH_DEF
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      i_push,
   input  logic [CNT_W-1:0]          i_push_dat,
   input  logic                      i_pop,
   output logic [CNT_W-1:0]          o_head_dat,
   output logic [occ_w(DEPTH)-1:0]   o_occ,
   output logic                      o_empty,
   output logic                      o_full
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned OW = occ_w(DEPTH);

   logic [CNT_W-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [OW-1:0]    r_cnt;

   logic w_empty;
   logic w_full;
   logic w_push;
   logic w_pop;

   // The extra pointer MSB separates full (MSBs differ) from empty (identical).
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

   // A pop in the same cycle frees the slot, so push is allowed at full then.
   assign w_pop  = i_pop && !w_empty;
   assign w_push = i_push && (!w_full || w_pop);

   assign o_head_dat = r_mem[r_rd_ptr[AW-1:0]];
   assign o_occ      = r_cnt;
   assign o_empty    = w_empty;
   assign o_full     = w_full;

   // Tag storage written at the tail; validity is tracked by the pointers, so no reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
      end
   end

   // Pointer and occupancy bookkeeping; reset discards every outstanding tag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
         end
         r_cnt <= r_cnt + OW'(w_push) - OW'(w_pop);
      end
   end

endmodule

// File: rtl/latency_tagger.sv
// purpose: time-stamps each rx start, retires tags in order on tx, reports latency and stats
// latency: every output registered; a cycle-t event is visible at t+1
// backpressure: none; rx while full is dropped (ovf_err), tx with no tag is flagged (orphan_err)
module latency_tagger
   import hft_ts_pkg::*;
#(
   parameter int unsigned CNT_W   = CNT_W_DEF,
   parameter int unsigned DEPTH   = DEPTH_DEF,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      rx_dv,
   input  logic                      tx_dv_in,
   input  logic                      stats_clr,
   output logic [CNT_W-1:0]          tx_timestamp,
   output logic                      tx_dv_out,
   output logic                      timeout_dv,
   output logic                      orphan_err,
   output logic                      ovf_err,
   output logic [occ_w(DEPTH)-1:0]   occupancy,
   output logic [CNT_W-1:0]          lat_min,
   output logic [CNT_W-1:0]          lat_max,
   output logic [CNT_W-1:0]          match_cnt
);

   localparam logic [CNT_W-1:0] TO_C  = CNT_W'(TIMEOUT);
   localparam bit               TO_EN = (TIMEOUT != 0);

   logic [CNT_W-1:0] r_now;
   logic [CNT_W-1:0] r_tx_ts;
   logic             r_tx_dv;
   logic             r_timeout;
   logic             r_orphan;
   logic             r_ovf;
   logic [CNT_W-1:0] r_lat_min;
   logic [CNT_W-1:0] r_lat_max;
   logic [CNT_W-1:0] r_match_cnt;

   logic [CNT_W-1:0] w_head;
   logic [CNT_W-1:0] w_age;
   logic             w_empty;
   logic             w_full;
   logic             w_head_vld;
   logic             w_match;
   logic             w_orphan;
   logic             w_timeout;
   logic             w_pop;
   logic             w_push;
   logic             w_ovf;

   // Only tags already stored at the start of the cycle can be popped (no bypass).
   assign w_head_vld = !w_empty;

   // Modular age of the head tag; wraps naturally in CNT_W bits.
   assign w_age = r_now - w_head;

   // A tx always takes the head as a match, even when the head is already stale.
   assign w_match   = tx_dv_in && w_head_vld;
   assign w_orphan  = tx_dv_in && !w_head_vld;
   assign w_timeout = TO_EN && w_head_vld && !tx_dv_in && (w_age >= TO_C);
   assign w_pop     = w_match || w_timeout;

   // A full FIFO still accepts rx when the same cycle retires its head.
   assign w_push = rx_dv && (!w_full || w_pop);
   assign w_ovf  = rx_dv && w_full && !w_pop;

   ts_tag_fifo #(
      .CNT_W (CNT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_push     (w_push),
      .i_push_dat (r_now),
      .i_pop      (w_pop),
      .o_head_dat (w_head),
      .o_occ      (occupancy),
      .o_empty    (w_empty),
      .o_full     (w_full)
   );

   // Free-running time base shared by tag capture and age calculation.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_now <= '0;
      end else begin
         r_now <= r_now + CNT_W'(1);
      end
   end

   // Registered match output and one-cycle event pulses; timestamp holds between matches.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_tx_ts   <= '0;
         r_tx_dv   <= 1'b0;
         r_timeout <= 1'b0;
         r_orphan  <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         r_tx_dv   <= w_match;
         r_timeout <= w_timeout;
         r_orphan  <= w_orphan;
         r_ovf     <= w_ovf;
         if (w_match) begin
            r_tx_ts <= w_age;
         end
      end
   end

   // Running statistics over matches only; a clear wins over a same-cycle match.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_lat_min   <= '1;
         r_lat_max   <= '0;
         r_match_cnt <= '0;
      end else if (stats_clr) begin
         r_lat_min   <= '1;
         r_lat_max   <= '0;
         r_match_cnt <= '0;
      end else if (w_match) begin
         if (w_age < r_lat_min) begin
            r_lat_min <= w_age;
         end
         if (w_age > r_lat_max) begin
            r_lat_max <= w_age;
         end
         if (r_match_cnt != '1) begin
            r_match_cnt <= r_match_cnt + CNT_W'(1);
         end
      end
   end

   assign tx_timestamp = r_tx_ts;
   assign tx_dv_out    = r_tx_dv;
   assign timeout_dv   = r_timeout;
   assign orphan_err   = r_orphan;
   assign ovf_err      = r_ovf;
   assign lat_min      = r_lat_min;
   assign lat_max      = r_lat_max;
   assign match_cnt    = r_match_cnt;

endmodule

// File: tb/tb_latency_tagger.sv
// purpose: self-checking bench; two instances (32-bit/no timeout, 8-bit/timeout 20) vs a queue model
// latency: outputs sampled 1 time unit after each rising edge
// backpressure: n/a
module tb_latency_tagger;
   import hft_ts_pkg::*;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned TO1   = 20;

   logic clk       = 1'b0;
   logic reset_n   = 1'b1;
   logic rx_dv     = 1'b0;
   logic tx_dv_in  = 1'b0;
   logic stats_clr = 1'b0;

   logic [31:0] ts0, min0, max0, cnt0;
   logic        dv0, to0, orp0, ovf0;
   logic [3:0]  occ0;
   logic [7:0]  ts1, min1, max1, cnt1;
   logic        dv1, to1, orp1, ovf1;
   logic [3:0]  occ1;

   int checks   = 0;
   int failures = 0;

   // Reference model state, one slot per instance: [0] 32-bit no timeout, [1] 8-bit timeout 20.
   longint unsigned m_mask [2] = '{64'hFFFF_FFFF, 64'hFF};
   int unsigned     m_to   [2] = '{0, TO1};
   longint unsigned m_now  [2];
   longint unsigned m_q    [2][$];
   longint unsigned m_ts   [2];
   longint unsigned m_min  [2];
   longint unsigned m_max  [2];
   longint unsigned m_cnt  [2];
   bit              m_dv   [2];
   bit              m_tov  [2];
   bit              m_orp  [2];
   bit              m_ovf  [2];

   always #5 clk = ~clk;

   latency_tagger #(.CNT_W(32), .DEPTH(DEPTH), .TIMEOUT(0)) dut0 (
      .clk(clk), .reset_n(reset_n), .rx_dv(rx_dv), .tx_dv_in(tx_dv_in), .stats_clr(stats_clr),
      .tx_timestamp(ts0), .tx_dv_out(dv0), .timeout_dv(to0), .orphan_err(orp0), .ovf_err(ovf0),
      .occupancy(occ0), .lat_min(min0), .lat_max(max0), .match_cnt(cnt0)
   );

   latency_tagger #(.CNT_W(8), .DEPTH(DEPTH), .TIMEOUT(TO1)) dut1 (
      .clk(clk), .reset_n(reset_n), .rx_dv(rx_dv), .tx_dv_in(tx_dv_in), .stats_clr(stats_clr),
      .tx_timestamp(ts1), .tx_dv_out(dv1), .timeout_dv(to1), .orphan_err(orp1), .ovf_err(ovf1),
      .occupancy(occ1), .lat_min(min1), .lat_max(max1), .match_cnt(cnt1)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_now[d] = 0;
         m_q[d].delete();
         m_ts[d]  = 0;
         m_min[d] = m_mask[d];
         m_max[d] = 0;
         m_cnt[d] = 0;
         m_dv[d]  = 0;
         m_tov[d] = 0;
         m_orp[d] = 0;
         m_ovf[d] = 0;
      end
   endtask

   // One clock of behaviour straight from the rules: retire first, then admit the new tag.
   task automatic model_cycle(input bit rx, input bit tx, input bit clr);
      for (int d = 0; d < 2; d++) begin
         longint unsigned age;
         m_dv[d]  = 0;
         m_tov[d] = 0;
         m_orp[d] = 0;
         m_ovf[d] = 0;
         age = (m_q[d].size() > 0) ? ((m_now[d] - m_q[d][0]) & m_mask[d]) : 0;
         if (tx && m_q[d].size() > 0) begin
            void'(m_q[d].pop_front());
            m_ts[d] = age;
            m_dv[d] = 1;
            if (!clr) begin
               if (age < m_min[d]) m_min[d] = age;
               if (age > m_max[d]) m_max[d] = age;
               if (m_cnt[d] != m_mask[d]) m_cnt[d] = m_cnt[d] + 1;
            end
         end else if (tx) begin
            m_orp[d] = 1;
         end else if (m_to[d] != 0 && m_q[d].size() > 0 && age >= m_to[d]) begin
            void'(m_q[d].pop_front());
            m_tov[d] = 1;
         end
         if (clr) begin
            m_min[d] = m_mask[d];
            m_max[d] = 0;
            m_cnt[d] = 0;
         end
         if (rx) begin
            if (m_q[d].size() < DEPTH) m_q[d].push_back(m_now[d]);
            else m_ovf[d] = 1;
         end
         m_now[d] = (m_now[d] + 1) & m_mask[d];
      end
   endtask

   task automatic compare_all();
      chk("d0.tx_timestamp", 64'(ts0),  m_ts[0]);
      chk("d0.tx_dv_out",    64'(dv0),  64'(m_dv[0]));
      chk("d0.timeout_dv",   64'(to0),  64'(m_tov[0]));
      chk("d0.orphan_err",   64'(orp0), 64'(m_orp[0]));
      chk("d0.ovf_err",      64'(ovf0), 64'(m_ovf[0]));
      chk("d0.occupancy",    64'(occ0), 64'(m_q[0].size()));
      chk("d0.lat_min",      64'(min0), m_min[0]);
      chk("d0.lat_max",      64'(max0), m_max[0]);
      chk("d0.match_cnt",    64'(cnt0), m_cnt[0]);
      chk("d1.tx_timestamp", 64'(ts1),  m_ts[1]);
      chk("d1.tx_dv_out",    64'(dv1),  64'(m_dv[1]));
      chk("d1.timeout_dv",   64'(to1),  64'(m_tov[1]));
      chk("d1.orphan_err",   64'(orp1), 64'(m_orp[1]));
      chk("d1.ovf_err",      64'(ovf1), 64'(m_ovf[1]));
      chk("d1.occupancy",    64'(occ1), 64'(m_q[1].size()));
      chk("d1.lat_min",      64'(min1), m_min[1]);
      chk("d1.lat_max",      64'(max1), m_max[1]);
      chk("d1.match_cnt",    64'(cnt1), m_cnt[1]);
   endtask

   // Called 1 unit after a rising edge: drive, take the edge, update model, sample.
   task automatic step(input bit rx, input bit tx, input bit clr);
      rx_dv     = rx;
      tx_dv_in  = tx;
      stats_clr = clr;
      @(posedge clk);
      model_cycle(rx, tx, clr);
      #1;
      rx_dv     = 1'b0;
      tx_dv_in  = 1'b0;
      stats_clr = 1'b0;
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
   endtask

   // Asserted away from any edge so the reset values must appear without a clock.
   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      #1;
      do_reset();
      chk("reset.lat_min_ones", 64'(min0), 64'hFFFF_FFFF);
      chk("reset.occupancy",    64'(occ0), 64'd0);

      // Single match: rx at cycle 10, tx at cycle 15.
      idle(10);
      step(1'b1, 1'b0, 1'b0);
      chk("single.occ_after_rx", 64'(occ0), 64'd1);
      idle(4);
      step(1'b0, 1'b1, 1'b0);
      chk("single.dv",   64'(dv0),  64'd1);
      chk("single.ts",   64'(ts0),  64'd5);
      chk("single.occ",  64'(occ0), 64'd0);
      chk("single.cnt",  64'(cnt0), 64'd1);
      chk("single.min",  64'(min0), 64'd5);
      chk("single.max",  64'(max0), 64'd5);
      idle(1);
      chk("single.dv_drop", 64'(dv0), 64'd0);
      chk("single.ts_hold", 64'(ts0), 64'd5);

      // Pipelined ordering: rx 0,1,2; tx 4,5,6.
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
      idle(1);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 1'b0);
         chk("pipe.ts", 64'(ts0), 64'd4);
      end

      // Mixed order: rx 0,1,2; tx 3,8,9.
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      chk("mixed.ts0", 64'(ts0), 64'd3);
      idle(4);
      step(1'b0, 1'b1, 1'b0);
      chk("mixed.ts1", 64'(ts0), 64'd7);
      step(1'b0, 1'b1, 1'b0);
      chk("mixed.ts2", 64'(ts0), 64'd7);
      chk("mixed.min", 64'(min0), 64'd3);
      chk("mixed.max", 64'(max0), 64'd7);

      // Full and empty boundaries.
      do_reset();
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);
      chk("full.no_ovf_yet", 64'(ovf0), 64'd0);
      step(1'b1, 1'b0, 1'b0);
      chk("full.ovf",  64'(ovf0), 64'd1);
      chk("full.occ",  64'(occ0), 64'd8);
      idle(1);
      chk("full.ovf_once", 64'(ovf0), 64'd0);
      step(1'b1, 1'b1, 1'b0);
      chk("full.rxtx_no_ovf", 64'(ovf0), 64'd0);
      chk("full.rxtx_occ",    64'(occ0), 64'd8);
      chk("full.rxtx_dv",     64'(dv0),  64'd1);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      chk("empty.orphan", 64'(orp0), 64'd1);
      chk("empty.no_dv",  64'(dv0),  64'd0);
      step(1'b1, 1'b1, 1'b0);
      chk("empty.rxtx_orphan", 64'(orp0), 64'd1);
      chk("empty.rxtx_occ",    64'(occ0), 64'd1);
      step(1'b0, 1'b1, 1'b0);

      // Timeout on the 8-bit/TIMEOUT=20 instance.
      do_reset();
      step(1'b1, 1'b0, 1'b0);
      idle(19);
      chk("tmo.not_yet", 64'(to1), 64'd0);
      idle(1);
      chk("tmo.pulse", 64'(to1),  64'd1);
      chk("tmo.occ",   64'(occ1), 64'd0);
      step(1'b0, 1'b1, 1'b0);
      chk("tmo.late_tx_orphan", 64'(orp1), 64'd1);
      chk("tmo.no_timeout_d0",  64'(to0),  64'd0);

      // tx exactly at the timeout threshold wins as a match.
      do_reset();
      step(1'b1, 1'b0, 1'b0);
      idle(19);
      step(1'b0, 1'b1, 1'b0);
      chk("tmo_edge.dv", 64'(dv1), 64'd1);
      chk("tmo_edge.ts", 64'(ts1), 64'd20);
      chk("tmo_edge.no_timeout", 64'(to1), 64'd0);

      // Counter wrap on the 8-bit instance: rx at now=250, tx 10 cycles later.
      do_reset();
      for (int i = 0; i < 300 && m_now[1] != 250; i++) step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      idle(9);
      step(1'b0, 1'b1, 1'b0);
      chk("wrap.ts", 64'(ts1), 64'd10);

      // Asynchronous reset with three tags outstanding.
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
      chk("areset.pre_occ", 64'(occ0), 64'd3);
      do_reset();
      chk("areset.occ", 64'(occ0), 64'd0);
      chk("areset.min", 64'(min1), 64'hFF);
      step(1'b0, 1'b1, 1'b0);
      chk("areset.orphan", 64'(orp0), 64'd1);

      // Statistics clear coinciding with a match.
      do_reset();
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      chk("clr.pre_cnt", 64'(cnt0), 64'd1);
      step(1'b0, 1'b1, 1'b1);
      chk("clr.dv",  64'(dv0),  64'd1);
      chk("clr.ts",  64'(ts0),  64'd2);
      chk("clr.cnt", 64'(cnt0), 64'd0);
      chk("clr.max", 64'(max0), 64'd0);
      chk("clr.min", 64'(min0), 64'hFFFF_FFFF);

      // Randomised traffic against the model.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         bit rx;
         bit tx;
         bit clr;
         rx  = ($urandom_range(99) < 50);
         tx  = ($urandom_range(99) < (i < 200 ? 40 : 15));
         clr = ($urandom_range(99) < 3);
         step(rx, tx, clr);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
